// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with AXI-Stream output.
//
// Deserialises the asynchronous rxd line (idle high, LSB first) into
// DATA_WIDTH-bit words. Each bit is decided by a 3-sample majority vote around
// the bit centre. Parity (none/even/odd) and stop-bit count (1/2) are latched
// at the start of every frame, so mid-frame changes do not disturb it.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   m_axis_tdata/tuser  : received word, {frame_err, parity_err}
//   m_axis_tvalid/tready: stream handshake
//   rxd                 : serial input (asynchronous)
//   busy                : frame (or break) in progress
//   overrun_error       : pulse, unread word overwritten
//   frame_error         : pulse, stop bit sampled low
//   parity_error        : pulse, parity mismatch
//   break_detect        : pulse, line break seen (no word emitted)
//   prescale            : clk/(baud*8), 0 parks the receiver in IDLE
//   parity_mode         : 00 none, 01 even, 10 odd, 11 none
//   stop_bits           : 0 one stop bit, 1 two stop bits
module uart_rx_cfg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]            m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  output logic                  parity_error,
  output logic                  break_detect,
  input  logic [15:0]           prescale,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK_WAIT
  } state_t;

  typedef struct packed {
    logic [15:0] pre;
    logic [1:0]  par;
    logic        stop2;
  } cfg_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  state_t                state, state_d;
  cfg_t                  cfg_q;
  logic                  rxd_m, rxd_s;
  logic [18:0]           cnt;
  logic                  s0, s1;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            bit_idx;
  logic                  stop_idx;
  logic                  par_bit_q;
  logic                  ferr_q;

  logic [18:0] half, bit_last;
  logic        smp0, smp1, smp2, bit_end;
  logic        vote, par_en, last_stop, brk_hit, perr_now, ferr_now;
  logic        start_go, complete, brk_evt, active;

  // Two-flop synchroniser; resets to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Sample points sit at the bit centre (4*prescale) and its neighbours.
  // prescale is >= 1 whenever these are used, so no underflow.
  assign half     = {1'b0, cfg_q.pre, 2'b00};
  assign bit_last = {cfg_q.pre, 3'b000} - 19'd1;
  assign smp0     = (cnt == half - 19'd1);
  assign smp1     = (cnt == half);
  assign smp2     = (cnt == half + 19'd1);
  assign bit_end  = (cnt == bit_last);

  // Third sample is the live synchronised value.
  assign vote = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);

  assign par_en    = (cfg_q.par == 2'b01) || (cfg_q.par == 2'b10);
  assign last_stop = (stop_idx == cfg_q.stop2);
  // Break is judged on the first stop bit only; par_bit_q stays 0 without parity.
  assign brk_hit   = !stop_idx && !vote && (data_q == '0) && !par_bit_q;
  // Odd mode (par[1]=1) wants XOR of data+parity = 1, even wants 0.
  assign perr_now  = par_en && ((^data_q ^ par_bit_q) != cfg_q.par[1]);
  assign ferr_now  = ferr_q | !vote;

  assign active = (state == START) || (state == DATA) ||
                  (state == PARITY) || (state == STOP);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    start_go = 1'b0;
    complete = 1'b0;
    brk_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s && (prescale != 16'd0)) begin
          state_d  = START;
          start_go = 1'b1;
        end
      end
      START: begin
        if (smp2 && vote)  state_d = IDLE;   // false start
        else if (bit_end)  state_d = DATA;
      end
      DATA: begin
        if (bit_end && (bit_idx == LAST_BIT))
          state_d = par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // Final stop bit ends at its third sample, not at the bit boundary,
        // so the next start edge can be caught as early as possible.
        if (smp2) begin
          if (brk_hit) begin
            state_d = BREAK_WAIT;
            brk_evt = 1'b1;
          end else if (last_stop) begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end
      end
      BREAK_WAIT: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timing and data capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q     <= '0;
      cnt       <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      data_q    <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_bit_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else if (start_go) begin
      cfg_q     <= '{pre: prescale, par: parity_mode, stop2: stop_bits};
      cnt       <= '0;
      data_q    <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      par_bit_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else if (active) begin
      cnt <= bit_end ? 19'd0 : cnt + 19'd1;
      if (smp0) s0 <= rxd_s;
      if (smp1) s1 <= rxd_s;
      if (smp2) begin
        case (state)
          DATA:    data_q    <= {vote, data_q[DATA_WIDTH-1:1]};
          PARITY:  par_bit_q <= vote;
          STOP:    ferr_q    <= ferr_now;
          default: ;
        endcase
      end
      if (bit_end) begin
        if (state == DATA) bit_idx  <= bit_idx + 4'd1;
        if (state == STOP) stop_idx <= 1'b1;
      end
    end
  end

  // Output register, handshake and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
      break_detect  <= 1'b0;
    end else begin
      overrun_error <= 1'b0;
      frame_error   <= 1'b0;
      parity_error  <= 1'b0;
      break_detect  <= brk_evt;
      if (complete) begin
        m_axis_tdata  <= data_q;
        m_axis_tuser  <= {ferr_now, perr_now};
        m_axis_tvalid <= 1'b1;
        // A word consumed on this very edge is not lost.
        overrun_error <= m_axis_tvalid && !m_axis_tready;
        frame_error   <= ferr_now;
        parity_error  <= perr_now;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: a table of clean/erroneous frames, plus
// hand-written sequences for overrun, false start, break, prescale=0,
// glitch rejection and mid-frame reset.
module tb_uart_rx_cfg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  tdata;
  logic [1:0]  tuser;
  logic        tvalid;
  logic        tready;
  logic        rxd;
  logic        busy, ovr, ferr, perr, brk;
  logic [15:0] prescale;
  logic [1:0]  parity_mode;
  logic        stop_bits;

  always #5 clk = ~clk;

  uart_rx_cfg #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_axis_tdata(tdata), .m_axis_tuser(tuser),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .rxd(rxd), .busy(busy),
    .overrun_error(ovr), .frame_error(ferr),
    .parity_error(perr), .break_detect(brk),
    .prescale(prescale), .parity_mode(parity_mode), .stop_bits(stop_bits)
  );

  int total = 0;
  int bad   = 0;

  // Monitor: sampled on the falling edge, between active edges.
  int cyc = 0;
  int beats = 0, vcyc = 0, n_ovr = 0, n_ferr = 0, n_perr = 0, n_brk = 0;
  int busy_cyc = 0, rise_cyc = 0;
  int last_data = 0, last_user = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tvalid) vcyc++;
    if (tvalid && !prev_v) rise_cyc = cyc;
    prev_v = tvalid;
    if (tvalid && tready) begin
      beats++;
      last_data = int'(tdata);
      last_user = int'(tuser);
    end
    if (ovr)  n_ovr++;
    if (ferr) n_ferr++;
    if (perr) n_perr++;
    if (brk)  n_brk++;
    if (busy) busy_cyc++;
  end

  int s_beats, s_vcyc, s_ovr, s_ferr, s_perr, s_brk, s_busy;

  task automatic snap();
    s_beats = beats; s_vcyc = vcyc; s_ovr = n_ovr; s_ferr = n_ferr;
    s_perr = n_perr; s_brk = n_brk; s_busy = busy_cyc;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive a frame LSB first; gbit>=0 inverts one cycle in the middle of that bit.
  task automatic send(input logic [15:0] bits, input int n, input int pre,
                      input int gbit);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8 * pre; j++) begin
        rxd = (i == gbit && j == 5) ? ~bits[i] : bits[i];
        tick();
      end
    rxd = 1'b1;
  endtask

  task automatic cfg(input int pre, input logic [1:0] pm, input logic sb);
    prescale = 16'(pre); parity_mode = pm; stop_bits = sb;
  endtask

  typedef struct {
    int          pre;
    logic [1:0]  pm;
    logic        sb;
    logic [15:0] bits;   // {stops, parity, data, start}
    int          n;
    int          exp_data;
    int          exp_user;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int t0;
    vecs[0] = '{1, 2'b00, 1'b0, 16'({1'b1, 8'h5A, 1'b0}),             10, 'h5A, 0};
    vecs[1] = '{2, 2'b01, 1'b0, 16'({1'b1, 1'b1, 8'h03, 1'b0}),       11, 'h03, 1};
    vecs[2] = '{2, 2'b01, 1'b0, 16'({1'b1, 1'b0, 8'h03, 1'b0}),       11, 'h03, 0};
    vecs[3] = '{1, 2'b10, 1'b1, 16'({1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}), 12, 'hA5, 2};
    vecs[4] = '{1, 2'b10, 1'b1, 16'({1'b1, 1'b1, 1'b1, 8'h11, 1'b0}), 12, 'h11, 0};
    vecs[5] = '{1, 2'b10, 1'b0, 16'({1'b1, 1'b0, 8'h00, 1'b0}),       11, 'h00, 1};
    vecs[6] = '{3, 2'b00, 1'b0, 16'({1'b0, 8'hFF, 1'b0}),             10, 'hFF, 2};
    vecs[7] = '{1, 2'b11, 1'b0, 16'({1'b1, 8'h81, 1'b0}),             10, 'h81, 0};
    vecs[8] = '{1, 2'b01, 1'b1, 16'({1'b1, 1'b0, 1'b0, 8'h3C, 1'b0}), 12, 'h3C, 2};

    rst_n = 1'b0; rxd = 1'b1; tready = 1'b1;
    cfg(1, 2'b00, 1'b0);
    ticks(3);
    chk("reset tdata",  int'(tdata), 0);
    chk("reset tuser",  int'(tuser), 0);
    chk("reset tvalid", int'(tvalid), 0);
    chk("reset busy",   int'(busy), 0);
    chk("reset pulses", int'({ovr, ferr, perr, brk}), 0);
    rst_n = 1'b1;
    ticks(3);

    // Table of single frames, consumer always ready.
    for (int k = 0; k < 9; k++) begin
      cfg(vecs[k].pre, vecs[k].pm, vecs[k].sb);
      snap();
      t0 = cyc;
      send(vecs[k].bits, vecs[k].n, vecs[k].pre, -1);
      ticks(10);
      chk($sformatf("v%0d beats", k), beats - s_beats, 1);
      chk($sformatf("v%0d tdata", k), last_data, vecs[k].exp_data);
      chk($sformatf("v%0d tuser", k), last_user, vecs[k].exp_user);
      chk($sformatf("v%0d tvalid cycles", k), vcyc - s_vcyc, 1);
      chk($sformatf("v%0d frame_error", k), n_ferr - s_ferr, vecs[k].exp_user / 2);
      chk($sformatf("v%0d parity_error", k), n_perr - s_perr, vecs[k].exp_user % 2);
      chk($sformatf("v%0d break/overrun", k), (n_brk - s_brk) + (n_ovr - s_ovr), 0);
      // 3 cycles rxd->start entry, then (bits-1)*T + 4*prescale + 2.
      chk($sformatf("v%0d latency", k), rise_cyc - t0,
          (vecs[k].n - 1) * 8 * vecs[k].pre + 4 * vecs[k].pre + 2 + 3);
      chk($sformatf("v%0d busy end", k), int'(busy), 0);
    end

    // Overrun: two words with no consumer.
    cfg(1, 2'b00, 1'b0);
    tready = 1'b0;
    snap();
    send(16'({1'b1, 8'h12, 1'b0}), 10, 1, -1);
    ticks(10);
    chk("ovr first tdata", int'(tdata), 'h12);
    chk("ovr first tvalid", int'(tvalid), 1);
    send(16'({1'b1, 8'h34, 1'b0}), 10, 1, -1);
    ticks(10);
    chk("ovr pulse", n_ovr - s_ovr, 1);
    chk("ovr tdata", int'(tdata), 'h34);
    chk("ovr tvalid held", int'(tvalid), 1);
    tready = 1'b1;
    ticks(5);
    chk("ovr beats", beats - s_beats, 1);
    chk("ovr last data", last_data, 'h34);
    chk("ovr tvalid drop", int'(tvalid), 0);

    // False start: 3-cycle low pulse at prescale 4.
    cfg(4, 2'b00, 1'b0);
    snap();
    rxd = 1'b0; ticks(3); rxd = 1'b1;
    ticks(60);
    chk("fs busy seen", int'((busy_cyc - s_busy) > 0), 1);
    chk("fs busy end", int'(busy), 0);
    chk("fs beats", (beats - s_beats) + (vcyc - s_vcyc), 0);
    chk("fs flags", (n_ferr - s_ferr) + (n_perr - s_perr) + (n_brk - s_brk), 0);

    // prescale 0 ignores the line.
    cfg(0, 2'b00, 1'b0);
    snap();
    rxd = 1'b0; ticks(30); rxd = 1'b1; ticks(5);
    chk("pre0 busy", busy_cyc - s_busy, 0);

    // Break: rxd low for 12 bit times, 8N1 prescale 1.
    cfg(1, 2'b00, 1'b0);
    snap();
    rxd = 1'b0; ticks(96);
    chk("brk pulse", n_brk - s_brk, 1);
    chk("brk no word", vcyc - s_vcyc, 0);
    chk("brk no ferr/perr", (n_ferr - s_ferr) + (n_perr - s_perr), 0);
    chk("brk busy held", int'(busy), 1);
    rxd = 1'b1; ticks(5);
    chk("brk busy release", int'(busy), 0);

    // One-cycle glitch in the middle of data bit 1 must not flip it.
    snap();
    send(16'({1'b1, 8'h5A, 1'b0}), 10, 1, 2);
    ticks(10);
    chk("glitch beats", beats - s_beats, 1);
    chk("glitch tdata", last_data, 'h5A);

    // Reset during data bit 4 with a word still pending.
    tready = 1'b0;
    snap();
    send(16'({1'b1, 8'h5A, 1'b0}), 10, 1, -1);
    ticks(10);
    chk("rst pending tvalid", int'(tvalid), 1);
    send(16'({1'b1, 8'hC3, 1'b0}), 5, 1, -1);
    rxd = 1'b0;               // bit 4 of 0xC3
    ticks(4);
    rst_n = 1'b0;
    ticks(2);
    chk("rst tvalid", int'(tvalid), 0);
    chk("rst tdata", int'(tdata), 0);
    chk("rst tuser", int'(tuser), 0);
    chk("rst busy", int'(busy), 0);
    rst_n = 1'b1; rxd = 1'b1; tready = 1'b1;
    ticks(20);
    chk("rst no flags", (n_ovr - s_ovr) + (n_ferr - s_ferr) + (n_perr - s_perr) +
        (n_brk - s_brk), 0);
    chk("rst no beat", beats - s_beats, 0);
    snap();
    send(16'({1'b1, 8'hC3, 1'b0}), 10, 1, -1);
    ticks(10);
    chk("post-rst beats", beats - s_beats, 1);
    chk("post-rst tdata", last_data, 'hC3);
    chk("post-rst tuser", last_user, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
